// File: rtl/logic_axi4_stream_packet_limiter.sv
// AXI4-Stream packet length limiter: forwards at most MAX_BEATS beats per packet, truncating longer ones.
// Optional truncation statistics counter enabled by macro LOGIC_AXI4_STREAM_PACKET_LIMITER_STATS_EN.
module logic_axi4_stream_packet_limiter #(
    parameter int TDATA_BYTES = 4,
    parameter int TDEST_WIDTH = 1,
    parameter int TUSER_WIDTH = 1,
    parameter int TID_WIDTH   = 1,
    parameter int MAX_BEATS   = 64
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     rx_tvalid,
    input  logic                     rx_tlast,
    input  logic [TDATA_BYTES*8-1:0] rx_tdata,
    input  logic [TDATA_BYTES-1:0]   rx_tstrb,
    input  logic [TDATA_BYTES-1:0]   rx_tkeep,
    input  logic [TDEST_WIDTH-1:0]   rx_tdest,
    input  logic [TUSER_WIDTH-1:0]   rx_tuser,
    input  logic [TID_WIDTH-1:0]     rx_tid,
    output logic                     rx_tready,
    output logic                     tx_tvalid,
    output logic                     tx_tlast,
    output logic [TDATA_BYTES*8-1:0] tx_tdata,
    output logic [TDATA_BYTES-1:0]   tx_tstrb,
    output logic [TDATA_BYTES-1:0]   tx_tkeep,
    output logic [TDEST_WIDTH-1:0]   tx_tdest,
    output logic [TUSER_WIDTH-1:0]   tx_tuser,
    output logic [TID_WIDTH-1:0]     tx_tid,
    input  logic                     tx_tready
`ifdef LOGIC_AXI4_STREAM_PACKET_LIMITER_STATS_EN
    ,
    output logic [31:0]              truncated_count
`endif
);

    localparam int CW = $clog2(MAX_BEATS + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BEATS - 1);
    localparam logic [TUSER_WIDTH-1:0] TRUNC_FLAG = TUSER_WIDTH'(1);

    typedef enum logic {
        ST_PASS = 1'b0,
        ST_DROP = 1'b1
    } state_e;

    state_e                   state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     tx_tvalid_q, tx_tvalid_d;
    logic                     tx_tlast_q, tx_tlast_d;
    logic [TDATA_BYTES*8-1:0] tx_tdata_q, tx_tdata_d;
    logic [TDATA_BYTES-1:0]   tx_tstrb_q, tx_tstrb_d;
    logic [TDATA_BYTES-1:0]   tx_tkeep_q, tx_tkeep_d;
    logic [TDEST_WIDTH-1:0]   tx_tdest_q, tx_tdest_d;
    logic [TUSER_WIDTH-1:0]   tx_tuser_q, tx_tuser_d;
    logic [TID_WIDTH-1:0]     tx_tid_q, tx_tid_d;

    logic rx_fire_s;
    logic load_s;
    logic trunc_s;

    // Ready depends only on registered state and downstream ready, never on rx_tvalid.
    assign rx_tready = (state_q == ST_DROP) ? 1'b1 : (!tx_tvalid_q || tx_tready);
    assign rx_fire_s = rx_tvalid && rx_tready;
    assign load_s    = rx_fire_s && (state_q == ST_PASS);
    assign trunc_s   = load_s && (cnt_q == LAST_CNT) && !rx_tlast;

    assign tx_tvalid = tx_tvalid_q;
    assign tx_tlast  = tx_tlast_q;
    assign tx_tdata  = tx_tdata_q;
    assign tx_tstrb  = tx_tstrb_q;
    assign tx_tkeep  = tx_tkeep_q;
    assign tx_tdest  = tx_tdest_q;
    assign tx_tuser  = tx_tuser_q;
    assign tx_tid    = tx_tid_q;

    // Next-state: output register load/drain and packet length tracking.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tx_tvalid_d = tx_tvalid_q;
        tx_tlast_d  = tx_tlast_q;
        tx_tdata_d  = tx_tdata_q;
        tx_tstrb_d  = tx_tstrb_q;
        tx_tkeep_d  = tx_tkeep_q;
        tx_tdest_d  = tx_tdest_q;
        tx_tuser_d  = tx_tuser_q;
        tx_tid_d    = tx_tid_q;
        case (state_q)
            ST_PASS: begin
                if (load_s) begin
                    tx_tvalid_d = 1'b1;
                    tx_tlast_d  = rx_tlast;
                    tx_tdata_d  = rx_tdata;
                    tx_tstrb_d  = rx_tstrb;
                    tx_tkeep_d  = rx_tkeep;
                    tx_tdest_d  = rx_tdest;
                    tx_tuser_d  = rx_tuser;
                    tx_tid_d    = rx_tid;
                    if (trunc_s) begin
                        // Limit reached mid-packet: close it here and swallow the remainder.
                        tx_tlast_d = 1'b1;
                        tx_tuser_d = rx_tuser | TRUNC_FLAG;
                        cnt_d      = '0;
                        state_d    = ST_DROP;
                    end else if (rx_tlast) begin
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else if (tx_tready) begin
                    tx_tvalid_d = 1'b0;
                end else begin
                    tx_tvalid_d = tx_tvalid_q;
                end
            end
            ST_DROP: begin
                if (tx_tready) begin
                    tx_tvalid_d = 1'b0;
                end else begin
                    tx_tvalid_d = tx_tvalid_q;
                end
                if (rx_fire_s && rx_tlast) begin
                    state_d = ST_PASS;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_DROP;
                end
            end
            default: begin
                state_d     = ST_PASS;
                cnt_d       = '0;
                tx_tvalid_d = 1'b0;
            end
        endcase
    end

    // State, counter and output register.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= ST_PASS;
            cnt_q       <= '0;
            tx_tvalid_q <= 1'b0;
            tx_tlast_q  <= 1'b0;
            tx_tdata_q  <= '0;
            tx_tstrb_q  <= '0;
            tx_tkeep_q  <= '0;
            tx_tdest_q  <= '0;
            tx_tuser_q  <= '0;
            tx_tid_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tx_tvalid_q <= tx_tvalid_d;
            tx_tlast_q  <= tx_tlast_d;
            tx_tdata_q  <= tx_tdata_d;
            tx_tstrb_q  <= tx_tstrb_d;
            tx_tkeep_q  <= tx_tkeep_d;
            tx_tdest_q  <= tx_tdest_d;
            tx_tuser_q  <= tx_tuser_d;
            tx_tid_q    <= tx_tid_d;
        end
    end

`ifdef LOGIC_AXI4_STREAM_PACKET_LIMITER_STATS_EN
    logic [31:0] trunc_cnt_q;

    assign truncated_count = trunc_cnt_q;

    // Saturating count of truncation events.
    always_ff @(posedge aclk) begin
        if (areset) begin
            trunc_cnt_q <= 32'h0000_0000;
        end else if (trunc_s && (trunc_cnt_q != 32'hFFFF_FFFF)) begin
            trunc_cnt_q <= trunc_cnt_q + 32'h0000_0001;
        end else begin
            trunc_cnt_q <= trunc_cnt_q;
        end
    end
`endif

endmodule

// File: doc/logic_axi4_stream_packet_limiter.md
LOGIC_AXI4_STREAM_PACKET_LIMITER -- requirements
Module: logic_axi4_stream_packet_limiter

Interface
- REQ-001 Parameter TDATA_BYTES, default 4, SHALL set tdata width in bytes (tstrb/tkeep width).
- REQ-002 Parameter TDEST_WIDTH, default 1, SHALL set tdest width.
- REQ-003 Parameter TUSER_WIDTH, default 1, SHALL set tuser width; bit 0 carries the truncation flag.
- REQ-004 Parameter TID_WIDTH, default 1, SHALL set tid width.
- REQ-005 Parameter MAX_BEATS, default 64, SHALL set the maximum packet length in beats (legal range >= 1).
- REQ-006 aclk  input  1  SHALL be the single clock; all logic on its rising edge.
- REQ-007 areset  input  1  SHALL be the reset, synchronous, active-high.
- REQ-008 rx_tvalid, rx_tlast  input  1 each; rx_tdata  input  TDATA_BYTES*8; rx_tstrb, rx_tkeep  input  TDATA_BYTES; rx_tdest  input  TDEST_WIDTH; rx_tuser  input  TUSER_WIDTH; rx_tid  input  TID_WIDTH: upstream AXI4-Stream beat.
- REQ-009 rx_tready  output  1  SHALL be the upstream ready.
- REQ-010 tx_* outputs SHALL mirror the rx_* fields, with tx_tready as input; tx_* feed the packet buffer Rx port.
- REQ-011 truncated_count  output  32  SHALL count truncated packets; present only under REQ-027.

Function
- REQ-012 Every beat passed SHALL traverse one output register: 1-cycle latency from rx handshake to tx_tvalid.
- REQ-013 rx_tready SHALL equal (!tx_tvalid || tx_tready) in PASS and 1 in DROP; no combinational path from rx_tvalid to rx_tready.
- REQ-014 The output register SHALL load when rx_tvalid && rx_tready in PASS, clear tx_tvalid when tx_tready && no load, and hold all tx_* stable while tx_tvalid && !tx_tready.
- REQ-015 FSM states SHALL be PASS and DROP; reset state PASS.
- REQ-016 Beat counter SHALL be $clog2(MAX_BEATS+1) bits, count accepted beats of the current packet starting at 1, and clear to 0 after any accepted beat carrying (forwarded or input) tlast.
- REQ-017 In PASS, a beat with count < MAX_BEATS SHALL be forwarded unchanged.
- REQ-018 In PASS, the MAX_BEATS-th beat with rx_tlast=1 SHALL be forwarded unchanged, state stays PASS.
- REQ-019 In PASS, the MAX_BEATS-th beat with rx_tlast=0 SHALL be forwarded with tx_tlast=1 and tx_tuser[0]=1 (other tuser bits unchanged), and state SHALL go to DROP.
- REQ-020 In DROP, every rx beat SHALL be accepted and discarded (tx_* unaffected); the beat with rx_tlast=1 SHALL return state to PASS with counter 0.
- REQ-021 MAX_BEATS=1: every beat SHALL be forwarded with tx_tlast=1; non-last inputs set tuser[0] and enter DROP.
- REQ-022 Simultaneous tx drain and rx load SHALL sustain one beat per cycle with no bubble.
- REQ-023 rx_tvalid low between beats SHALL not affect counter or state.

Reset
- REQ-024 On areset: tx_tvalid=0, tx_tlast=0, tx_tdata/tstrb/tkeep/tdest/tuser/tid=0, state PASS, counter 0, truncated_count=0.
- REQ-025 Reset asserted mid-packet SHALL discard the held beat and partial count; the next accepted beat SHALL be beat 1 of a new packet.
- REQ-026 rx_tready SHALL be 1 in the cycle after reset deasserts.

Configuration
- REQ-027 With macro LOGIC_AXI4_STREAM_PACKET_LIMITER_STATS_EN defined, truncated_count SHALL exist, increment by 1 on each REQ-019 event, saturate at 32'hFFFF_FFFF; without it the port and counter SHALL be absent and behaviour otherwise identical.

Verification (MAX_BEATS=4, tx_tready=1 unless stated)
- REQ-028 3-beat packet, tlast on beat 3 -> 3 beats out unchanged, tuser[0]=0, 1-cycle latency.
- REQ-029 4-beat packet, tlast on beat 4 -> 4 beats out unchanged, state PASS, no truncation.
- REQ-030 7-beat packet, data 1..7 -> beats 1..4 out, beat 4 tlast=1 tuser[0]=1; beats 5..7 accepted, not forwarded; truncated_count=1 with macro.
- REQ-031 Truncated packet immediately followed by 2-beat packet -> second packet out intact, counter restarted at 1.
- REQ-032 tx_tready toggled 1,0,0,1 during 3-beat packet -> tx_* stable while stalled, no loss or duplication, rx_tready low only while the register is full and stalled.
- REQ-033 areset pulsed after beat 2 of 6-beat packet, then 4-beat packet -> tx_tvalid=0 after reset, new packet out unchanged, no truncation.
